// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator result path.
//
// Contents:
//   BCD_DIGITS    - number of decimal digits on the display path.
//   BIN_WIDTH     - width of the binary result coming out of the ALU.
//   DABBLE_LAST   - terminal value of the 4-bit shift counter.
//   DIV0_SENTINEL - raw value the divider drives on divide-by-zero. It is
//                   documented here for reference only; the formatter never
//                   decodes it and relies solely on the in_err flag.
//   fmt_state_t   - formatter FSM states.
package calc_pkg;

    localparam int BCD_DIGITS = 5;
    localparam int BIN_WIDTH  = 16;

    localparam logic [3:0]  DABBLE_LAST   = 4'd15;
    localparam logic [15:0] DIV0_SENTINEL = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fmt_state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational shift-and-add-3 step.
//
// Ports:
//   bcd      in  4*DIGITS  packed BCD accumulator, digit 0 in [3:0]
//   shift_in in  1         next binary bit (MSB first) to shift into the LSB
//   bcd_next out 4*DIGITS  corrected, shifted accumulator
//
// Each digit that is 5 or more gets +3 before the shift, so that the doubling
// carries correctly into the next decimal digit.
module bcd_dabble_step #(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd,
    input  logic                shift_in,
    output logic [4*DIGITS-1:0] bcd_next
);

    logic [4*DIGITS-1:0] adj;
    // The bit shifted out of the top digit. With a 16-bit magnitude the value
    // never exceeds 65535, so this bit is always zero and is dropped.
    logic                unused_carry;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        bcd_next     = {adj[4*DIGITS-2:0], shift_in};
        unused_carry = adj[4*DIGITS-1];
    end

endmodule

// File: rtl/result_bcd_formatter.sv
// result_bcd_formatter: sequential binary-to-BCD converter for the calculator
// result path. Converts a 16-bit ALU result (signed or unsigned) into a sign
// flag plus five BCD digits, one double-dabble step per clock.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   in_data/in_signed/in_err valid
//   in_ready   out  1   high only while idle
//   in_data    in   16  binary result
//   in_signed  in   1   1 = two's complement, 0 = unsigned
//   in_err     in   1   divide-by-zero; data ignored
//   out_valid  out  1   result fields valid, held until accepted
//   out_ready  in   1   display driver accepts
//   out_bcd    out  20  digit 4 (MSD) in [19:16] ... digit 0 in [3:0]
//   out_neg    out  1   result negative
//   out_err    out  1   error result, out_bcd = 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until then, and
// valid never drops before the transfer. out_* stay frozen while out_valid=1.
//
// Latency from the accept edge T: out_valid rises after edge T+16 for a
// normal result and after edge T+1 for an error result.
module result_bcd_formatter
    import calc_pkg::*;
#(
    parameter int WIDTH  = BIN_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_signed,
    input  logic                in_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_neg,
    output logic                out_err
);

    fmt_state_t          state;
    logic [WIDTH-1:0]    mag;
    logic [4*DIGITS-1:0] bcd;
    logic [4*DIGITS-1:0] bcd_next;
    logic [3:0]          cnt;
    logic                neg_q;
    logic                err_q;
    logic                in_neg;

    assign in_neg = in_signed & in_data[WIDTH-1];

    bcd_dabble_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .bcd      (bcd),
        .shift_in (mag[WIDTH-1]),
        .bcd_next (bcd_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mag       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_neg   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Magnitude is kept unsigned, so -32768 becomes 32768.
                        mag      <= in_neg ? (~in_data + {{(WIDTH-1){1'b0}}, 1'b1})
                                           : in_data;
                        neg_q    <= in_neg;
                        err_q    <= in_err;
                        bcd      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (err_q) begin
                        // Error overrides data and sign: one cycle, then done.
                        out_bcd   <= '0;
                        out_neg   <= 1'b0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        bcd <= bcd_next;
                        mag <= {mag[WIDTH-2:0], 1'b0};
                        cnt <= cnt + 4'd1;
                        if (cnt == DABBLE_LAST) begin
                            out_bcd   <= bcd_next;
                            out_neg   <= neg_q;
                            out_err   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Bench for result_bcd_formatter: directed vectors, a decimal reference model,
// and one negedge compare process that checks every cycle out_valid is high.
module tb_result_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic        in_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_bcd;
    logic        out_neg;
    logic        out_err;

    result_bcd_formatter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_err    (in_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_neg   (out_neg),
        .out_err   (out_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Entry layout: {due_cycle[15:0], err, neg, bcd[19:0]}
    logic [37:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: decimal digits by repeated division, sign from the raw bits.
    function automatic logic [21:0] model(input logic [15:0] d, input logic s, input logic e);
        logic [19:0] b;
        logic        n;
        int          m;
        b = '0;
        if (e) return {1'b1, 1'b0, 20'h0};
        n = s && (d >= 16'h8000);
        m = n ? (65536 - int'(d)) : int'(d);
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {1'b0, n, b};
    endfunction

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [37:0] e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!prev_valid) check("latency_cycle", 32'(cyc), 32'(e[37:22]));
                    check("out_bcd", 32'(out_bcd), 32'(e[19:0]));
                    check("out_neg", 32'(out_neg), 32'(e[20]));
                    check("out_err", 32'(out_err), 32'(e[21]));
                    check("in_ready_while_done", 32'(in_ready), 32'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [15:0] d, input logic s, input logic e);
        int          n;
        int          due;
        n = 0;
        in_data   = d;
        in_signed = s;
        in_err    = e;
        in_valid  = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        due = cyc + (e ? 1 : 16);
        exp_q.push_back({16'(due), model(d, s, e)});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [15:0] d;
        logic        s;
        logic        e;
        logic [21:0] exp;   // {err, neg, bcd}
    } vec_t;

    vec_t vecs[9] = '{
        '{16'h3039, 1'b0, 1'b0, 22'h012345},
        '{16'hFFFF, 1'b1, 1'b0, 22'h100001},
        '{16'h8000, 1'b1, 1'b0, 22'h132768},
        '{16'hFFFF, 1'b0, 1'b0, 22'h065535},
        '{16'h0000, 1'b0, 1'b0, 22'h000000},
        '{16'hFFFE, 1'b1, 1'b1, 22'h200000},
        '{16'h7FFF, 1'b1, 1'b0, 22'h032767},
        '{16'hFF9C, 1'b1, 1'b0, 22'h100100},
        '{16'h03E7, 1'b0, 1'b0, 22'h000999}
    };

    initial begin
        int n;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bcd",   32'(out_bcd),   32'd0);
        check("rst_out_neg",   32'(out_neg),   32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed conversions, out_ready held high
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            check("model_pin", 32'(model(vecs[i].d, vecs[i].s, vecs[i].e)), 32'(vecs[i].exp));
            send(vecs[i].d, vecs[i].s, vecs[i].e);
            wait_idle();
        end

        // Back-pressure, with a stray in_valid pulse during SHIFT
        out_ready = 1'b0;
        send(16'd12345, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        in_data  = 16'd4321;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_reached_done", 32'(out_valid), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("bp_held_valid", 32'(out_valid), 32'd1);
        check("bp_held_bcd",   32'(out_bcd),   32'h12345);
        check("bp_in_ready",   32'(in_ready),  32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        wait_idle();

        // Reset in the middle of SHIFT
        send(16'd30000, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_bcd",   32'(out_bcd),   32'd0);
        check("midrst_out_neg",   32'(out_neg),   32'd0);
        check("midrst_out_err",   32'(out_err),   32'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_pulse", 32'(out_valid), 32'd0);
        send(16'd999, 1'b0, 1'b0);
        wait_idle();
        check("final_bcd", 32'(out_bcd), 32'h00999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
